// File: rtl/switch_debouncer.sv
// Slide-switch conditioning: two-flop synchroniser, per-bit stability
// counter, clean level output plus change pulse, sticky mask and IRQ.
module switch_debouncer #(
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic [NUM_SW-1:0] iSwitches_raw,
    input  logic              iClear_change,
    output logic [NUM_SW-1:0] oSwitches_data,
    output logic              oChange_pulse,
    output logic [NUM_SW-1:0] oChange_mask,
    output logic              oIrq
);

    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0]    sync1;
    logic [NUM_SW-1:0]    sync2;
    logic [NUM_SW-1:0]    stable;
    logic [NUM_SW-1:0]    differ;
    logic [NUM_SW-1:0]    atLast;
    logic [NUM_SW-1:0]    accept;
    logic [CNT_WIDTH-1:0] count [NUM_SW];

    // Bring the asynchronous pins into the iClk domain
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= iSwitches_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit disagreement and acceptance decode
    always_comb begin
        differ = sync2 ^ stable;
        atLast = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            atLast[i] = (count[i] == LAST);
        end
        accept = differ & atLast;
    end

    // Stability counters: run while the input disagrees, restart otherwise
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < NUM_SW; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (!differ[i] || atLast[i]) begin
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + 1'b1;
                end
            end
        end
    end

    // Accepted levels, change pulse and sticky mask (set beats clear)
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            stable        <= '0;
            oChange_pulse <= 1'b0;
            oChange_mask  <= '0;
        end else begin
            stable        <= stable ^ accept;
            oChange_pulse <= |accept;
            oChange_mask  <= (iClear_change ? '0 : oChange_mask)
                             | accept;
        end
    end

    assign oSwitches_data = stable;
    assign oIrq           = |oChange_mask;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios and random switch
// activity checked every cycle against a timestamp-based reference.
module tb_switch_debouncer;

    localparam int NSW = 10;
    localparam int DB  = 4;

    logic           iClk;
    logic           iReset_n;
    logic [NSW-1:0] iSwitches_raw;
    logic           iClear_change;
    logic [NSW-1:0] oSwitches_data;
    logic           oChange_pulse;
    logic [NSW-1:0] oChange_mask;
    logic           oIrq;

    int total = 0;
    int bad   = 0;

    switch_debouncer #(
        .NUM_SW         (NSW),
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH      (3)
    ) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iSwitches_raw (iSwitches_raw),
        .iClear_change (iClear_change),
        .oSwitches_data(oSwitches_data),
        .oChange_pulse (oChange_pulse),
        .oChange_mask  (oChange_mask),
        .oIrq          (oIrq)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Reference: raw value seen by the logic is the one from two edges
    // ago; a bit is accepted when it has disagreed with the accepted
    // level for DB edges since it last agreed or was last accepted.
    logic [NSW-1:0] mData;
    logic [NSW-1:0] mMask;
    logic           mPulse;
    logic [NSW-1:0] rawQ [2];
    int             edgeNo;
    int             quietEdge [NSW];

    always @(posedge iClk or negedge iReset_n) begin
        logic [NSW-1:0] seen;
        logic [NSW-1:0] acc;
        if (!iReset_n) begin
            mData  = '0;
            mMask  = '0;
            mPulse = 1'b0;
            rawQ[0] = '0;
            rawQ[1] = '0;
            edgeNo = 0;
            for (int i = 0; i < NSW; i++) quietEdge[i] = 0;
        end else begin
            edgeNo++;
            seen = rawQ[1];
            acc  = '0;
            for (int i = 0; i < NSW; i++) begin
                if (seen[i] == mData[i]) begin
                    quietEdge[i] = edgeNo;
                end else if (edgeNo - quietEdge[i] == DB) begin
                    acc[i] = 1'b1;
                    quietEdge[i] = edgeNo;
                end
            end
            mData  = mData ^ acc;
            mPulse = |acc;
            mMask  = (iClear_change ? '0 : mMask) | acc;
            rawQ[1] = rawQ[0];
            rawQ[0] = iSwitches_raw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock, then compare every output against the reference
    task automatic tick();
        @(posedge iClk);
        @(negedge iClk);
        chk("data", 32'(oSwitches_data), 32'(mData));
        chk("pulse", 32'(oChange_pulse), 32'(mPulse));
        chk("mask", 32'(oChange_mask), 32'(mMask));
        chk("irq", 32'(oIrq), 32'(|mMask));
    endtask

    // Called just after a falling edge; releases before the next rise
    task automatic doReset(input logic [NSW-1:0] r);
        iSwitches_raw = r;
        iReset_n = 1'b0;
        #1;
        chk("rst_data", 32'(oSwitches_data), 32'h0);
        chk("rst_pulse", 32'(oChange_pulse), 32'h0);
        chk("rst_mask", 32'(oChange_mask), 32'h0);
        chk("rst_irq", 32'(oIrq), 32'h0);
        #3;
        iReset_n = 1'b1;
    endtask

    initial begin
        iReset_n = 1'b0;
        iSwitches_raw = '1;
        iClear_change = 1'b0;
        @(negedge iClk);

        // Switches high through reset: initial position reported at edge 6
        doReset(10'h3FF);
        repeat (5) tick();
        chk("pwr_pre", 32'(oSwitches_data), 32'h0);
        tick();
        chk("pwr_data", 32'(oSwitches_data), 32'h3FF);
        chk("pwr_mask", 32'(oChange_mask), 32'h3FF);
        chk("pwr_irq", 32'(oIrq), 32'h1);
        chk("pwr_pulse", 32'(oChange_pulse), 32'h1);
        tick();
        chk("pwr_pulse1", 32'(oChange_pulse), 32'h0);

        // Clean step on bit3
        doReset(10'h000);
        repeat (3) tick();
        iSwitches_raw = 10'h008;
        repeat (5) tick();
        chk("step_pre", 32'(oSwitches_data), 32'h0);
        tick();
        chk("step_data", 32'(oSwitches_data), 32'h008);
        chk("step_mask", 32'(oChange_mask), 32'h008);
        chk("step_pulse", 32'(oChange_pulse), 32'h1);
        tick();
        chk("step_pulse1", 32'(oChange_pulse), 32'h0);

        // Bounce on bit0: 3 high, 1 low, then hold high
        doReset(10'h000);
        repeat (3) tick();
        for (int c = 0; c < 40; c++) begin
            iSwitches_raw = (c % 4 == 3) ? 10'h000 : 10'h001;
            tick();
            chk("bnc_hold", 32'(oSwitches_data), 32'h0);
        end
        iSwitches_raw = 10'h001;
        repeat (5) tick();
        chk("bnc_pre", 32'(oSwitches_data), 32'h0);
        tick();
        chk("bnc_data", 32'(oSwitches_data), 32'h001);
        chk("bnc_mask", 32'(oChange_mask), 32'h001);

        // Clear and set on the same edge
        doReset(10'h000);
        repeat (3) tick();
        iSwitches_raw = 10'h001;
        repeat (8) tick();
        chk("col_setup", 32'(oChange_mask), 32'h001);
        iSwitches_raw = 10'h021;
        repeat (5) tick();
        iClear_change = 1'b1;
        tick();
        iClear_change = 1'b0;
        chk("col_mask", 32'(oChange_mask), 32'h020);
        chk("col_irq", 32'(oIrq), 32'h1);
        chk("col_data", 32'(oSwitches_data), 32'h021);
        iClear_change = 1'b1;
        tick();
        iClear_change = 1'b0;
        chk("clr_mask", 32'(oChange_mask), 32'h0);
        chk("clr_irq", 32'(oIrq), 32'h0);

        // Two bits on one edge
        doReset(10'h000);
        repeat (3) tick();
        iSwitches_raw = 10'h201;
        repeat (6) tick();
        chk("sim_data", 32'(oSwitches_data), 32'h201);
        chk("sim_mask", 32'(oChange_mask), 32'h201);
        chk("sim_pulse", 32'(oChange_pulse), 32'h1);
        tick();
        chk("sim_pulse1", 32'(oChange_pulse), 32'h0);

        // Reset in the middle of a count on bit7
        doReset(10'h000);
        repeat (3) tick();
        iSwitches_raw = 10'h080;
        repeat (5) tick();
        doReset(10'h080);
        repeat (5) tick();
        chk("mid_pre", 32'(oSwitches_data), 32'h0);
        tick();
        chk("mid_data", 32'(oSwitches_data), 32'h080);

        // Random activity with varied hold times and clears
        doReset(10'h000);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0)
                iSwitches_raw[$urandom_range(0, NSW - 1)] ^= 1'b1;
            iClear_change = ($urandom_range(0, 11) == 0);
            tick();
            if ($urandom_range(0, 3) == 0) begin
                iClear_change = 1'b0;
                repeat ($urandom_range(1, 7)) tick();
            end
        end
        iClear_change = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
